vga_pixel_timing: RTL and testbench
===================================

// Module: vga_pixel_timing
// PURPOSE
//  Upstream stage of the background / object drawing blocks. Generates 640x480@60 VGA raster timing from the system clock.
//  Provides pixelX/pixelY scan coordinates consumed by the background drawer and object drawers, plus sync, blanking and frame strobes.
//  The output mux and VGA DAC interface use the sync, blanking and frame strobes.
// PARAMETERS
//  CLK_DIV   2    system clocks per pixel (1..8); 50 MHz clk -> 25 MHz pixel rate
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
// PORTS
//  clk           in   1   system clock
//  resetN        in   1   reset; active-HIGH, synchronous, despite the name
//  pixelX        out  11  horizontal position 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800)
//  pixelY        out  11  vertical position 0..V_TOTAL-1 (V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP=525)
//  pixelTick     out  1   one-clk strobe; coordinates advance on the clk edge ending this cycle
//  blankN        out  1   1 = (pixelX,pixelY) in visible area
//  hsync         out  1   horizontal sync, active low
//  vsync         out  1   vertical sync, active low
//  startOfFrame  out  1   one-clk pulse in the cycle pixelX/pixelY first read (0,0) after a frame wrap
// BEHAVIOUR
//  - All outputs are registered; no combinational path from any input to any output.
//  - Reset (resetN=1 at clk edge):
//    - divCnt=0, pixelX=0, pixelY=0, pixelTick=0.
//    - blankN=1, hsync=1, vsync=1, startOfFrame=0.
//    - Reset mid-frame aborts the frame immediately; no startOfFrame is issued for it.
//  - Divider: divCnt counts 0..CLK_DIV-1 and wraps.
//    - pixelTick=1 in the clk cycle where divCnt==CLK_DIV-1.
//    - CLK_DIV=1: pixelTick=1 every cycle after reset.
//  - Counters: state changes only on edges where pixelTick=1; otherwise all outputs hold.
//    - pixelX increments; at H_TOTAL-1 it wraps to 0 and pixelY increments.
//    - pixelY at V_TOTAL-1 with pixelX wrap -> pixelY wraps to 0.
//    - Both are unsigned 11-bit; H_TOTAL and V_TOTAL must be <= 2047.
//  - Decode: blankN, hsync and vsync are registered from the NEXT counter values.
//    - They always describe the coordinates present on the same cycle (zero relative latency).
//    - blankN = (pixelX < H_ACTIVE) && (pixelY < V_ACTIVE).
//    - hsync = 0 iff H_ACTIVE+H_FP <= pixelX < H_ACTIVE+H_FP+H_SYNC (656..751).
//    - vsync = 0 iff V_ACTIVE+V_FP <= pixelY < V_ACTIVE+V_FP+V_SYNC (490..491); spans whole lines.
//  - startOfFrame: set on the edge that wraps (H_TOTAL-1,V_TOTAL-1) -> (0,0); cleared on the next edge.
//    - Width is exactly 1 clk regardless of CLK_DIV.
//    - Not asserted for the first frame after reset.
//  - Coordinates keep counting through blanking; consumers must gate drawing with blankN.
//  - Frame period = H_TOTAL*V_TOTAL*CLK_DIV clks = 840000 clks at defaults.
// TESTING
//  1. resetN=1 for 5 clks, release -> outputs (0,0), blankN=1, hsync=1, vsync=1; first pixelTick on 2nd clk after release; pixelX=1 after it.
//  2. Run 800 pixelTicks -> pixelX 799->0 with pixelY 0->1; hsync low for exactly 96 ticks (pixelX 656..751).
//  3. Run 2 full frames -> startOfFrame exactly once per frame at wrap to (0,0), width 1 clk; vsync low for 1600 ticks (pixelY 490..491).
//  4. Count blankN=1 ticks over one frame -> 307200; blankN=0 whenever pixelX>=640 or pixelY>=480.
//  5. Assert resetN for 1 clk at (300,200) -> next cycle reset values, restart from (0,0), no startOfFrame until the next full wrap.
//  6. CLK_DIV=1 -> pixelTick constant 1; frame = 420000 clks; CLK_DIV=4 -> frame = 1680000 clks, same sync tick counts.

Source files
------------

// File: rtl/vga_pixel_timing.sv
// VGA raster timing generator: pixel-rate divider, X/Y scan counters and
// registered sync/blank/frame strobes aligned with the coordinates they describe.
module vga_pixel_timing #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk,
    input  logic        resetN,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        pixelTick,
    output logic        blankN,
    output logic        hsync,
    output logic        vsync,
    output logic        startOfFrame
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] divCnt;
    logic [DIV_W-1:0] divNext;
    logic [10:0]      xNext;
    logic [10:0]      yNext;
    logic             tickNext;
    logic             sofNext;

    always_comb begin
        divNext  = (divCnt == DIV_LAST) ? '0 : divCnt + DIV_W'(1);
        tickNext = (divNext == DIV_LAST);
        xNext    = pixelX;
        yNext    = pixelY;
        sofNext  = 1'b0;
        if (pixelTick) begin
            if (pixelX == H_LAST) begin
                xNext = '0;
                if (pixelY == V_LAST) begin
                    yNext   = '0;
                    sofNext = 1'b1;
                end else begin
                    yNext = pixelY + 11'd1;
                end
            end else begin
                xNext = pixelX + 11'd1;
            end
        end
    end

    // Decode from the next coordinates so strobes line up with pixelX/pixelY.
    always_ff @(posedge clk) begin
        if (resetN) begin
            divCnt       <= '0;
            pixelX       <= '0;
            pixelY       <= '0;
            pixelTick    <= 1'b0;
            blankN       <= 1'b1;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            startOfFrame <= 1'b0;
        end else begin
            divCnt       <= divNext;
            pixelX       <= xNext;
            pixelY       <= yNext;
            pixelTick    <= tickNext;
            blankN       <= (xNext < H_VIS) && (yNext < V_VIS);
            hsync        <= !((xNext >= HS_START) && (xNext < HS_END));
            vsync        <= !((yNext >= VS_START) && (yNext < VS_END));
            startOfFrame <= sofNext;
        end
    end

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Bench for vga_pixel_timing: one default-timing instance plus three reduced-raster
// instances (CLK_DIV 1/2/4) checked against an arithmetic model of the raster.
module tb_vga_pixel_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   k = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [10:0] ox[4];
    logic [10:0] oy[4];
    logic        ot[4], ob[4], oh[4], ov[4], os[4];

    vga_pixel_timing #(.CLK_DIV(2)) u_def (
        .clk(clk), .resetN(rst), .pixelX(ox[0]), .pixelY(oy[0]), .pixelTick(ot[0]),
        .blankN(ob[0]), .hsync(oh[0]), .vsync(ov[0]), .startOfFrame(os[0]));

    vga_pixel_timing #(.CLK_DIV(1), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
                       .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)) u_d1 (
        .clk(clk), .resetN(rst), .pixelX(ox[1]), .pixelY(oy[1]), .pixelTick(ot[1]),
        .blankN(ob[1]), .hsync(oh[1]), .vsync(ov[1]), .startOfFrame(os[1]));

    vga_pixel_timing #(.CLK_DIV(2), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
                       .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)) u_d2 (
        .clk(clk), .resetN(rst), .pixelX(ox[2]), .pixelY(oy[2]), .pixelTick(ot[2]),
        .blankN(ob[2]), .hsync(oh[2]), .vsync(ov[2]), .startOfFrame(os[2]));

    vga_pixel_timing #(.CLK_DIV(4), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
                       .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)) u_d4 (
        .clk(clk), .resetN(rst), .pixelX(ox[3]), .pixelY(oy[3]), .pixelTick(ot[3]),
        .blankN(ob[3]), .hsync(oh[3]), .vsync(ov[3]), .startOfFrame(os[3]));

    // k = clock edges since the last edge that sampled reset
    always @(posedge clk) k <= rst ? 0 : k + 1;

    // field: 0 D, 1 HA, 2 HFP, 3 HS, 4 HB, 5 VA, 6 VFP, 7 VS, 8 VB
    function automatic int par(int i, int f);
        int def[9];
        int sml[9];
        def = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
        sml = '{1, 10, 2, 3, 2, 6, 1, 2, 2};
        if (i == 0) return def[f];
        if (f == 0) return (i == 1) ? 1 : (i == 2) ? 2 : 4;
        return sml[f];
    endfunction

    function automatic int htot(int i);
        return par(i, 1) + par(i, 2) + par(i, 3) + par(i, 4);
    endfunction

    function automatic int frame(int i);
        return htot(i) * (par(i, 5) + par(i, 6) + par(i, 7) + par(i, 8));
    endfunction

    // Strobe is high in cycles whose index is the last of each divider period;
    // with a divide of 1 the first cycle after reset is still low.
    function automatic bit tick_at(int i, int kk);
        int d = par(i, 0);
        if (d == 1) return kk > 0;
        return (kk % d) == d - 1;
    endfunction

    // Number of pixel advances that have happened before cycle kk.
    function automatic int pix(int i, int kk);
        int d = par(i, 0);
        if (d == 1) return (kk > 0) ? kk - 1 : 0;
        return kk / d;
    endfunction

    function automatic logic [26:0] model(int i, int kk);
        int n, x, y, ha, va;
        bit tk, bl, hs, vs, sof;
        n  = pix(i, kk) % frame(i);
        x  = n % htot(i);
        y  = n / htot(i);
        ha = par(i, 1);
        va = par(i, 5);
        tk = tick_at(i, kk);
        bl = (x < ha) && (y < va);
        hs = !((x >= ha + par(i, 2)) && (x < ha + par(i, 2) + par(i, 3)));
        vs = !((y >= va + par(i, 6)) && (y < va + par(i, 6) + par(i, 7)));
        sof = (kk > 0) && tick_at(i, kk - 1) && (pix(i, kk) > 0) && (n == 0);
        return {11'(x), 11'(y), tk, bl, hs, vs, sof};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({ox[i], oy[i], ot[i], ob[i], oh[i], ov[i], os[i]} !== {11'd0, 11'd0, 5'b01110}) begin
                n_fail++;
                $display("FAIL reset_state inst%0d got x=%0d y=%0d t/b/h/v/s=%b%b%b%b%b want 0,0,01110",
                         i, ox[i], oy[i], ot[i], ob[i], oh[i], ov[i], os[i]);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({ot[0], ox[0]} !== {1'b1, 11'd0}) begin
            n_fail++;
            $display("FAIL first_tick got tick=%b x=%0d want tick=1 x=0", ot[0], ox[0]);
        end
        @(negedge clk);
        n_checks++;
        if ({ot[0], ox[0]} !== {1'b0, 11'd1}) begin
            n_fail++;
            $display("FAIL after_first_tick got tick=%b x=%0d want tick=0 x=1", ot[0], ox[0]);
        end
    endtask

    task automatic test_line();
        int hs_low = 0;
        int guard  = 0;
        while (pix(0, k) < 802 && guard < 2000) begin
            @(negedge clk);
            guard++;
            n_checks++;
            if ({ox[0], oy[0], ot[0], ob[0], oh[0], ov[0], os[0]} !== model(0, k)) begin
                n_fail++;
                $display("FAIL line_scan k=%0d got %h want %h", k,
                         {ox[0], oy[0], ot[0], ob[0], oh[0], ov[0], os[0]}, model(0, k));
            end
            if (ot[0] && !oh[0] && pix(0, k) < 800) hs_low++;
        end
        n_checks++;
        if (hs_low != 96 || guard >= 2000) begin
            n_fail++;
            $display("FAIL hsync_width got %0d ticks (guard %0d) want 96", hs_low, guard);
        end
    endtask

    task automatic test_frames();
        int vs_low[4] = '{0, 0, 0, 0};
        int vis[4]    = '{0, 0, 0, 0};
        int sofc[4]   = '{0, 0, 0, 0};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        while (k < 2 * frame(3) * 4 + 6) begin
            @(negedge clk);
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if ({ox[i], oy[i], ot[i], ob[i], oh[i], ov[i], os[i]} !== model(i, k)) begin
                    n_fail++;
                    $display("FAIL frame_scan inst%0d k=%0d got %h want %h", i, k,
                             {ox[i], oy[i], ot[i], ob[i], oh[i], ov[i], os[i]}, model(i, k));
                end
                if (ot[i] && pix(i, k) < 2 * frame(i)) begin
                    if (!ov[i]) vs_low[i]++;
                    if (ob[i]) vis[i]++;
                end
                if (os[i]) sofc[i]++;
            end
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (vs_low[i] != 2 * 17 * 2) begin
                n_fail++;
                $display("FAIL vsync_ticks inst%0d got %0d want %0d", i, vs_low[i], 68);
            end
            n_checks++;
            if (vis[i] != 2 * 10 * 6) begin
                n_fail++;
                $display("FAIL visible_ticks inst%0d got %0d want %0d", i, vis[i], 120);
            end
            n_checks++;
            if (sofc[i] != pix(i, k) / frame(i)) begin
                n_fail++;
                $display("FAIL sof_count inst%0d got %0d want %0d", i, sofc[i], pix(i, k) / frame(i));
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int cycles;
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b0;
            cycles = $urandom_range(20, 900);
            for (int c = 0; c < cycles; c++) begin
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    n_checks++;
                    if ({ox[i], oy[i], ot[i], ob[i], oh[i], ov[i], os[i]} !== model(i, k)) begin
                        n_fail++;
                        $display("FAIL random_scan inst%0d k=%0d got %h want %h", i, k,
                                 {ox[i], oy[i], ot[i], ob[i], oh[i], ov[i], os[i]}, model(i, k));
                    end
                end
                rst = ($urandom_range(0, 299) == 0);
            end
            rst = 1'b0;
        end
    endtask

    task automatic test_clkdiv();
        int first[4]  = '{-1, -1, -1, -1};
        int second[4] = '{-1, -1, -1, -1};
        int guard = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        while (second[3] < 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
            for (int i = 1; i < 4; i++) begin
                if (os[i]) begin
                    if (first[i] < 0) first[i] = k;
                    else if (second[i] < 0) second[i] = k;
                end
            end
            if (k > 0) begin
                n_checks++;
                if (ot[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL div1_tick k=%0d got %b want 1", k, ot[1]);
                end
            end
        end
        for (int i = 1; i < 4; i++) begin
            int d = par(i, 0);
            n_checks++;
            if (second[i] < 0 || second[i] - first[i] != 187 * d) begin
                n_fail++;
                $display("FAIL frame_period inst%0d got %0d want %0d", i, second[i] - first[i], 187 * d);
            end
            n_checks++;
            if (first[i] != ((d == 1) ? 188 : 187 * d)) begin
                n_fail++;
                $display("FAIL first_sof inst%0d got k=%0d want %0d", i, first[i], (d == 1) ? 188 : 187 * d);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_line();
        test_frames();
        test_random();
        test_clkdiv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
